// File: rtl/mvau_weight_loader.sv
// ---------------------------------------------------------------------------
// mvau_weight_loader
//
// Streams weight words from an AXI-Stream slave into PE separate weight
// memories. Beats are distributed PE-major: the first WMEM_DEPTH beats fill
// memory 0 (addresses 0..WMEM_DEPTH-1), the next WMEM_DEPTH fill memory 1,
// and so on, for PE*WMEM_DEPTH beats in total. Every accepted beat becomes
// exactly one registered write one cycle later.
//
// Optional feature (macro MVAU_WLOAD_ERR_EN):
//   Adds a sticky load_err output that flags tlast framing errors (tlast on
//   a non-final beat, or a final beat without tlast). Cleared by start in
//   IDLE. Without the macro the port is absent and tlast is ignored.
//
// Ports:
//   aclk           rising-edge clock
//   aresetn        asynchronous active-low reset
//   start          single-cycle pulse, begins a load (only honoured in IDLE)
//   s_axis_tdata   weight word, SIMD*TW bits
//   s_axis_tvalid  stream valid
//   s_axis_tlast   stream last (only used with MVAU_WLOAD_ERR_EN)
//   s_axis_tready  stream ready, high only while loading
//   wmem_wr_en     one-hot memory write enable, PE bits
//   wmem_wr_addr   write address, WMEM_ADDR_BW bits
//   wmem_wr_data   write data, SIMD*TW bits
//   busy           high while loading
//   done           single-cycle pulse coinciding with the final write
//   load_err       sticky framing error (MVAU_WLOAD_ERR_EN only)
// ---------------------------------------------------------------------------
module mvau_weight_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [PE-1:0]           wmem_wr_en,
    output logic [WMEM_ADDR_BW-1:0] wmem_wr_addr,
    output logic [SIMD*TW-1:0]      wmem_wr_data,
    output logic                    busy,
    output logic                    done
`ifdef MVAU_WLOAD_ERR_EN
    ,
    output logic                    load_err
`endif
);

    localparam int DW    = SIMD * TW;
    localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic [PE_BW-1:0]        pe_q, pe_d;
    logic [PE-1:0]           wr_en_q, wr_en_d;
    logic [WMEM_ADDR_BW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]           wr_data_q, wr_data_d;

    logic start_load;
    logic beat_accept;
    logic last_beat;

    // A start pulse only counts while idle; outside IDLE it is dropped.
    assign start_load  = (state_q == IDLE) && start;

    // tready is a pure decode of LOAD, so tvalid in any other state is
    // never accepted, including the start cycle itself.
    assign beat_accept = (state_q == LOAD) && s_axis_tvalid;

    // The final beat is the last address of the last memory.
    assign last_beat   = (addr_q == ADDR_LAST) && (pe_q == PE_LAST);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE lasts exactly one cycle and then falls back
    // to IDLE regardless of inputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start)                     state_d = LOAD;
            LOAD: if (beat_accept && last_beat)  state_d = DONE;
            DONE:                                state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Address / PE counters. They clear when a load begins so that a load
    // cut short by reset, or any stale state, never leaks into the next
    // load. Without an accepted beat they simply hold, which is how tvalid
    // gaps stall the sequence without dropping data.
    always_comb begin
        addr_d = addr_q;
        pe_d   = pe_q;
        if (start_load) begin
            addr_d = '0;
            pe_d   = '0;
        end else if (beat_accept) begin
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                pe_d   = (pe_q == PE_LAST) ? '0 : pe_q + PE_BW'(1);
            end else begin
                addr_d = addr_q + WMEM_ADDR_BW'(1);
            end
        end
    end

    // Write port next values. The enable is one-hot on the current PE for
    // one cycle per accepted beat; address and data hold between writes.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (beat_accept) begin
            wr_en_d   = PE'(1) << pe_q;
            wr_addr_d = addr_q;
            wr_data_d = s_axis_tdata;
        end
    end

    // Counter and write-port registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            pe_q      <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            pe_q      <= pe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Status outputs decode straight from the state register, so reset
    // clears them immediately.
    assign s_axis_tready = (state_q == LOAD);
    assign busy          = (state_q == LOAD);
    assign done          = (state_q == DONE);

    assign wmem_wr_en    = wr_en_q;
    assign wmem_wr_addr  = wr_addr_q;
    assign wmem_wr_data  = wr_data_q;

`ifdef MVAU_WLOAD_ERR_EN
    logic err_q, err_d;

    // Sticky framing error: tlast must appear on the final beat and only
    // there. It is purely observational and never alters the write order.
    always_comb begin
        err_d = err_q;
        if (start_load) begin
            err_d = 1'b0;
        end else if (beat_accept && (s_axis_tlast != last_beat)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign load_err = err_q;
`else
    // tlast has no function in this build.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_mvau_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_mvau_weight_loader
//
// Self-checking bench for mvau_weight_loader at default parameters. A
// behavioural model tracks "loading or not" and a beat index k; each accepted
// beat k is expected to appear as a write to memory k/WMEM_DEPTH at address
// k%WMEM_DEPTH one cycle later. Directed scenarios are followed by a random
// phase. With MVAU_WLOAD_ERR_EN defined, load_err is checked as well.
// ---------------------------------------------------------------------------
module tb_mvau_weight_loader;

    localparam int SIMD   = 2;
    localparam int TW     = 1;
    localparam int PE     = 2;
    localparam int DEPTH  = 4;
    localparam int ABW    = 4;
    localparam int DW     = SIMD * TW;
    localparam int NBEATS = PE * DEPTH;

    logic           aclk    = 1'b0;
    logic           aresetn = 1'b0;
    logic           start   = 1'b0;
    logic [DW-1:0]  tdata   = '0;
    logic           tvalid  = 1'b0;
    logic           tlast   = 1'b0;
    logic           tready;
    logic [PE-1:0]  wrEn;
    logic [ABW-1:0] wrAddr;
    logic [DW-1:0]  wrData;
    logic           busy;
    logic           done;
`ifdef MVAU_WLOAD_ERR_EN
    logic           loadErr;
`endif

    mvau_weight_loader #(
        .SIMD         (SIMD),
        .TW           (TW),
        .PE           (PE),
        .WMEM_DEPTH   (DEPTH),
        .WMEM_ADDR_BW (ABW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .wmem_wr_en    (wrEn),
        .wmem_wr_addr  (wrAddr),
        .wmem_wr_data  (wrData),
        .busy          (busy),
        .done          (done)
`ifdef MVAU_WLOAD_ERR_EN
        ,
        .load_err      (loadErr)
`endif
    );

    always #5 aclk = ~aclk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    bit             mLoading;
    int             mBeat;
    bit             mDone;
    logic [PE-1:0]  expEn;
    logic [ABW-1:0] expAddr;
    logic [DW-1:0]  expData;
    bit             expErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLoading = 1'b0;
        mBeat    = 0;
        mDone    = 1'b0;
        expEn    = '0;
        expAddr  = '0;
        expData  = '0;
        expErr   = 1'b0;
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".wr_en"},   32'(wrEn),   32'(expEn));
        checkOutput({where, ".wr_addr"}, 32'(wrAddr), 32'(expAddr));
        checkOutput({where, ".wr_data"}, 32'(wrData), 32'(expData));
        checkOutput({where, ".done"},    32'(done),   32'(mDone));
        checkOutput({where, ".busy"},    32'(busy),   32'(mLoading));
        checkOutput({where, ".tready"},  32'(tready), 32'(mLoading));
`ifdef MVAU_WLOAD_ERR_EN
        checkOutput({where, ".load_err"}, 32'(loadErr), 32'(expErr));
`endif
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic applyReset();
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        start   = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model over the next rising
    // edge, then compare all outputs shortly after that edge.
    task automatic applyStimulus(input bit st, input bit vld,
                                 input logic [DW-1:0] dat, input bit lst);
        bit nextDone;
        @(negedge aclk);
        start  = st;
        tvalid = vld;
        tdata  = dat;
        tlast  = lst;
        #1;
        checkOutput("tready_pre", 32'(tready), 32'(mLoading));

        nextDone = 1'b0;
        if (mLoading && vld) begin
            expEn   = PE'(1) << (mBeat / DEPTH);
            expAddr = ABW'(mBeat % DEPTH);
            expData = dat;
            if (lst != (mBeat == NBEATS - 1)) expErr = 1'b1;
            mBeat++;
            if (mBeat == NBEATS) begin
                mLoading = 1'b0;
                mBeat    = 0;
                nextDone = 1'b1;
            end
        end else begin
            expEn = '0;
            if (!mLoading && !mDone && st) begin
                mLoading = 1'b1;
                mBeat    = 0;
                expErr   = 1'b0;
            end
        end
        mDone = nextDone;

        @(posedge aclk);
        #1;
        checkAll("cycle");
    endtask

    initial begin
        modelReset();
        #1;
        checkAll("por");
        applyReset();

        // Continuous valid, start and tvalid together in the first cycle
        // (that beat must be dropped), then eight back-to-back beats.
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        for (int k = 0; k < NBEATS; k++)
            applyStimulus(1'b0, 1'b1, DW'(k), k == NBEATS - 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Valid toggling every other cycle.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0, k = 0; i < 2 * NBEATS; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b0, 1'b1, DW'(NBEATS - 1 - k), k == NBEATS - 1);
                k++;
            end else begin
                applyStimulus(1'b0, 1'b0, DW'(i), 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Reset after the third beat, then a fresh complete load.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, DW'(k + 1), 1'b0);
        applyReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < NBEATS; k++)
            applyStimulus(1'b0, 1'b1, DW'($urandom), k == NBEATS - 1);

        // Start pulses during LOAD and DONE, tvalid held high in IDLE.
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        for (int k = 0; k < NBEATS; k++)
            applyStimulus(k == 2 || k == 4, 1'b1, DW'(k), k == NBEATS - 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);

        // Framing: tlast on beat 5, then tlast only on the final beat.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < NBEATS; k++)
            applyStimulus(1'b0, 1'b1, DW'(k), k == 5);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < NBEATS; k++)
            applyStimulus(1'b0, 1'b1, DW'(k + 2), k == NBEATS - 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Random phase with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0,
                              $urandom_range(0, 3) != 0,
                              DW'($urandom),
                              (mBeat == NBEATS - 1) ? ($urandom_range(0, 7) != 0)
                                                    : ($urandom_range(0, 15) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
